// File: rtl/div_tick_pkg.sv
// Shared types and constants for the divider-tick BCD counter.
package div_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int         BCD_W         = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Packs a decimal value into up to 16 BCD digits, digit 0 in [3:0].
    function automatic logic [63:0] to_bcd(input int value);
        logic [63:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 16; i++) begin
            r[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter; ripple carry-out to the next digit.
module bcd_digit
    import div_tick_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             wrap,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    assign cout = inc & (q == BCD_MAX_DIGIT);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr || wrap) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == BCD_MAX_DIGIT) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/div_tick_bcd_counter.sv
// Turns the divider's square wave into ticks and counts them modulo MAX+1 in BCD
// under start/stop/clear control.
module div_tick_bcd_counter
    import div_tick_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MAX    = 59
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    output logic                  tick,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                  carry,
    output logic                  running
);

    localparam int                CW           = BCD_W * DIGITS;
    localparam logic [63:0]       MAX_BCD_FULL = to_bcd(MAX);
    localparam logic [CW-1:0]     MAX_BCD      = MAX_BCD_FULL[CW-1:0];

    logic        prev;
    logic        rise;
    state_t      state;
    state_t      next_state;
    logic        advance;
    logic        at_max;
    logic        wrap;
    logic [DIGITS-1:0] inc_chain;
    logic [DIGITS-1:0] cout_chain;
    logic        unused_msd_cout;

    assign rise    = div_in & ~prev;
    assign advance = rise & (state == RUN) & ~clr;
    assign at_max  = (count == MAX_BCD);
    assign wrap    = advance & at_max;

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!stop && start) next_state = RUN;
                RUN:     if (stop)           next_state = PAUSE;
                PAUSE:   if (!stop && start) next_state = RUN;
                default:                     next_state = IDLE;
            endcase
        end
    end

    // prev resets high so a div_in already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev    <= 1'b1;
            state   <= IDLE;
            tick    <= 1'b0;
            carry   <= 1'b0;
            running <= 1'b0;
        end else begin
            prev    <= div_in;
            state   <= next_state;
            tick    <= rise;
            carry   <= wrap;
            running <= (next_state == RUN);
        end
    end

    assign inc_chain[0] = advance & ~at_max;

    for (genvar i = 1; i < DIGITS; i++) begin : g_chain
        assign inc_chain[i] = cout_chain[i-1];
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .inc  (inc_chain[i]),
            .wrap (wrap),
            .q    (count[i*BCD_W +: BCD_W]),
            .cout (cout_chain[i])
        );
    end

    // The top digit never carries out below MAX; the wrap is handled by compare.
    assign unused_msd_cout = cout_chain[DIGITS-1];

endmodule

// File: tb/tb_div_tick_bcd_counter.sv
// Scoreboard bench: a decimal reference model predicts every cycle's outputs.
module tb_div_tick_bcd_counter;

    localparam int DIGITS = 2;
    localparam int MAX    = 59;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_in;
    logic       start;
    logic       stop;
    logic       clr;
    logic       tick;
    logic [7:0] count;
    logic       carry;
    logic       running;

    div_tick_bcd_counter #(.DIGITS(DIGITS), .MAX(MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_in  (div_in),
        .start   (start),
        .stop    (stop),
        .clr     (clr),
        .tick    (tick),
        .count   (count),
        .carry   (carry),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [7:0] count;
        logic       carry;
        logic       running;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_failed   = 0;

    // Reference model state: 0 idle, 1 run, 2 pause; count kept in decimal.
    int   m_prev  = 1;
    int   m_state = 0;
    int   m_count = 0;
    int   phase   = 6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step(input logic d, input logic st, input logic sp,
                        input logic cl, input logic r);
        exp_t e;
        int   rise;
        int   adv;
        int   ns;
        div_in = d; start = st; stop = sp; clr = cl; rst = r;
        if (!r) begin
            m_prev = 1; m_state = 0; m_count = 0;
            e = '{1'b0, 8'h00, 1'b0, 1'b0};
        end else begin
            rise = (d && m_prev == 0) ? 1 : 0;
            adv  = (rise == 1 && m_state == 1 && !cl) ? 1 : 0;
            e.tick  = (rise == 1);
            e.carry = (adv == 1 && m_count == MAX);
            if (cl)           m_count = 0;
            else if (adv == 1) m_count = (m_count == MAX) ? 0 : m_count + 1;
            ns = m_state;
            if (cl)                          ns = 0;
            else if (m_state == 1 && sp)     ns = 2;
            else if (m_state != 1 && !sp && st) ns = 1;
            m_state   = ns;
            m_prev    = d ? 1 : 0;
            e.count   = bcd(m_count);
            e.running = (m_state == 1);
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("tick",    {31'b0, tick},    {31'b0, e.tick});
        check("count",   {24'b0, count},   {24'b0, e.count});
        check("carry",   {31'b0, carry},   {31'b0, e.carry});
        check("running", {31'b0, running}, {31'b0, e.running});
    endtask

    // One clock of the divide-by-10 square wave: low 5, high 5.
    task automatic dcyc(input logic st, input logic sp, input logic cl);
        step(phase >= 5, st, sp, cl, 1'b1);
        phase = (phase + 1) % 10;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) dcyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_count(input int target, input string tag);
        int budget = 0;
        while (m_count != target && budget < 2000) begin
            dcyc(1'b0, 1'b0, 1'b0);
            budget++;
        end
        check(tag, {24'b0, count}, {24'b0, bcd(target)});
    endtask

    // Advance until the next driven cycle is a rising edge of div_in.
    task automatic align_to_rise();
        while (phase != 5) dcyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        div_in = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Reset held with div_in high, then released with it still high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("no_tick_at_release", {31'b0, tick}, 32'd0);

        // Basic count: ten ticks reach BCD 10.
        dcyc(1'b1, 1'b0, 1'b0);
        check("running_after_start", {31'b0, running}, 32'd1);
        run_until_count(10, "count_10");
        run_until_count(59, "count_59");
        run_until_count(0, "wrap_to_0");
        check("wrap_carry", {31'b0, carry}, 32'd1);
        dcyc(1'b0, 1'b0, 1'b0);
        check("carry_one_cycle", {31'b0, carry}, 32'd0);

        // Pause at 07, five ticks pass, then resume.
        run_until_count(7, "count_07");
        dcyc(1'b0, 1'b1, 1'b0);
        run(50);
        check("paused_hold", {24'b0, count}, 32'h07);
        dcyc(1'b1, 1'b0, 1'b0);
        run_until_count(8, "resume_08");

        // clr coincident with a wrapping rise.
        run_until_count(59, "count_59_again");
        align_to_rise();
        dcyc(1'b0, 1'b0, 1'b1);
        check("clr_tick", {31'b0, tick}, 32'd1);
        check("clr_count", {24'b0, count}, 32'h00);
        check("clr_carry", {31'b0, carry}, 32'd0);

        // start and stop together in IDLE: stays IDLE.
        dcyc(1'b1, 1'b1, 1'b0);
        check("idle_start_stop", {31'b0, running}, 32'd0);
        run(12);

        // start on the rising edge: no increment on that edge.
        align_to_rise();
        dcyc(1'b1, 1'b0, 1'b0);
        check("start_on_rise", {24'b0, count}, 32'h00);
        run_until_count(1, "after_start_rise");

        // Mid-run reset at 33, then a rise without start.
        run_until_count(33, "count_33");
        step(phase >= 5, 1'b1, 1'b0, 1'b0, 1'b0);
        phase = (phase + 1) % 10;
        check("mid_reset_count", {24'b0, count}, 32'h00);
        run(12);
        check("post_reset_idle", {24'b0, count}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/div_tick_bcd_counter.md
Name: div_tick_bcd_counter

Overview:
Stage directly downstream of the divide-by-10 divider. Consumes the divider's slow square-wave output (in the same clk domain) and produces one clk-wide tick per rising edge. Accumulates gated ticks in a modulo-(MAX+1) BCD counter with start/stop/clear control, giving a decimal event or time-base count for display and timing logic.

Parameters:
DIGITS, 2, number of BCD digits; count width = 4*DIGITS
MAX, 59, terminal count; count wraps MAX -> 0; legal range 1 .. 10^DIGITS-1

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  synchronous, active-low reset (rst==0 at posedge clk resets)
div_in  input  1  divider output; square wave synchronous to clk
start  input  1  level-sampled; request RUN
stop  input  1  level-sampled; request PAUSE
clr  input  1  synchronous clear of count and FSM
tick  output  1  one-cycle pulse per div_in rising edge
count  output  4*DIGITS  BCD count; digit 0 in [3:0]
carry  output  1  one-cycle pulse on wrap MAX -> 0
running  output  1  high while FSM is in RUN

Behaviour:
- Reset (rst==0 at posedge clk): prev=1, state=IDLE, count=0, tick=0, carry=0, running=0. prev resets to 1 so a div_in already high at reset release does not produce a tick.
- Edge detect: rise = div_in & ~prev. Every non-reset cycle: prev <= div_in.
- tick is registered: tick <= rise. It pulses in every FSM state; clr does not suppress it.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - Any state: clr -> IDLE.
- FSM priority: clr > stop > start. start and stop together in IDLE: stay IDLE. In PAUSE: stay PAUSE.
- running <= (next state == RUN), so it is registered and aligned with the state.
- Count update on a posedge with rise==1, current state RUN, and clr==0:
  - if count==MAX: count <= 0 and carry <= 1;
  - else count <= count+1 in BCD, where digit 9 -> 0 carries into the next digit.
  - The new count becomes visible in the same cycle as tick.
- carry is 0 on every other cycle.
- A state change is not seen by the count logic until the next edge. Example: start and rise together in IDLE gives no increment on that edge.
- clr: count <= 0 and carry <= 0 on that edge, even if rise or wrap coincide.
- PAUSE holds count. IDLE holds count at 0.
- Latency: div_in sampled high, with prev 0 -> tick, count and carry update on the next clk edge (1 cycle).
- Non-BCD count values are unreachable; no recovery logic is required.
- Reset mid-operation: every register returns to its reset value on that edge, regardless of other inputs.

Decomposition:
- Package div_tick_pkg:
  - state enum {IDLE, RUN, PAUSE};
  - BCD_W=4;
  - BCD_MAX_DIGIT=4'd9.
- Sub-module bcd_digit: inputs clk, rst, clr, inc (carry-in).
  - inc && q==9: q -> 0, cout=1.
  - wrap: synchronous load of 0, for the terminal-count clear.
  - cout is combinational: inc & (q==9).
- Top level: instantiates DIGITS bcd_digit copies chained by cout. The MAX compare and wrap are done at top level, not inside the digits.

Test Plan:
- Reset: hold rst=0 with div_in=1 and clocking, then release with div_in=1 held -> no tick; count=0, running=0, carry=0.
- Basic count: drive div_in from the divide-by-10 pattern (rising edge every 10 clk); pulse start 1 cycle -> running=1; tick every 10 cycles; count 00,01,…,09,10 (BCD 8'h10 after 10 ticks).
- Wrap: DIGITS=2, MAX=59. Run 60 ticks from 0 -> count=8'h59 after 59 ticks; 60th tick gives count=8'h00 and carry=1 for exactly 1 cycle, coincident with tick.
- Pause/resume: stop at count 8'h07 -> 5 more ticks, count stays 8'h07, tick still pulses, running=0. Then start -> next tick gives 8'h08.
- Simultaneous events:
  - clr on the same edge as a rise at count 8'h59 -> count=0, carry=0, tick=1, state IDLE.
  - start+stop together in IDLE -> stays IDLE.
  - start on the edge of a rise -> no increment on that edge.
- Mid-run reset: rst=0 for 1 cycle at count 8'h33 while in RUN -> count=0, IDLE, running=0; a subsequent rise with no start gives tick only, count stays 0.
